// File: rtl/ovi_issue_sched.sv
// Issue scheduler between the scalar instruction source and the OVI vector core.
// Each accepted instruction is metered against core issue credits and tagged
// with the lowest free scoreboard ID. Tags are retired on completion. For stores,
// the expected 512-bit store-data beats are counted and credited back one by one.
module ovi_issue_sched #(
    parameter int INIT_CREDITS = 4,
    parameter int NUM_TAGS     = 32,
    parameter int TAG_W        = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HALT,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    input  logic [31:0]      INSTR,
    input  logic [14:0]      INSTR_VL,
    input  logic [1:0]       INSTR_SEW,
    input  logic             INSTR_IS_STORE,
    output logic             ISSUE_VALID,
    output logic [31:0]      ISSUE_INSTR,
    output logic [14:0]      ISSUE_VL,
    output logic [1:0]       ISSUE_SEW,
    output logic [TAG_W-1:0] ISSUE_SB_ID,
    input  logic             ISSUE_CREDIT,
    input  logic             COMPLETED_VALID,
    input  logic [TAG_W-1:0] COMPLETED_SB_ID,
    input  logic             STORE_VALID,
    output logic             STORE_CREDIT,
    output logic [TAG_W:0]   IN_FLIGHT,
    output logic             DRAINED,
    output logic             ERR
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_STORE_RX = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         credits_q, credits_d;
    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [TAG_W:0]     in_flight_q, in_flight_d;
    logic [31:0]        instr_q, instr_d;
    logic [14:0]        vl_q, vl_d;
    logic [1:0]         sew_q, sew_d;
    logic               is_store_q, is_store_d;
    logic [TAG_W-1:0]   sb_id_q, sb_id_d;
    logic [12:0]        beats_q, beats_d;
    logic [12:0]        beat_cnt_q, beat_cnt_d;
    logic               store_credit_q, store_credit_d;
    logic               err_q, err_d;

    logic               any_free;
    logic [TAG_W-1:0]   alloc_tag;
    logic               handshake;
    logic               complete_ok;
    logic [21:0]        bit_count;
    logic [12:0]        beats_calc;
    logic [NUM_TAGS-1:0] alloc_hot;
    logic [NUM_TAGS-1:0] free_hot;

    // Lowest-index free tag; the scan runs downwards so the lowest index wins.
    always_comb begin
        alloc_tag = '0;
        any_free  = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_tag = TAG_W'(i);
                any_free  = 1'b1;
            end
        end
    end

    // Ready is also held low while reset is asserted so every output shows its reset value.
    assign INSTR_READY = (state_q == S_IDLE) && !HALT && (credits_q != 4'd0) && any_free && !RST;
    assign handshake   = INSTR_VALID && INSTR_READY;
    assign complete_ok = COMPLETED_VALID && busy_q[COMPLETED_SB_ID];

    // Store payload size in bits (VL * element width) and beats rounded up to 512 bits.
    assign bit_count  = {7'd0, INSTR_VL} << (3 + INSTR_SEW);
    assign beats_calc = bit_count[21:9] + {12'd0, |bit_count[8:0]};

    // One-hot allocate/free strobes per tag.
    for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
        assign alloc_hot[gi] = handshake && (alloc_tag == TAG_W'(gi));
        assign free_hot[gi]  = complete_ok && (COMPLETED_SB_ID == TAG_W'(gi));
    end

    // Tag mask, in-flight count and credit bookkeeping.
    always_comb begin
        busy_d      = (busy_q | alloc_hot) & ~free_hot;
        in_flight_d = in_flight_q;
        if (handshake && !complete_ok) begin
            in_flight_d = in_flight_q + (TAG_W+1)'(1);
        end else if (!handshake && complete_ok) begin
            in_flight_d = in_flight_q - (TAG_W+1)'(1);
        end

        credits_d = credits_q;
        if ((state_q == S_ISSUE) && !ISSUE_CREDIT) begin
            credits_d = credits_q - 4'd1;
        end else if ((state_q != S_ISSUE) && ISSUE_CREDIT && (credits_q != 4'(INIT_CREDITS))) begin
            credits_d = credits_q + 4'd1;
        end
    end

    // Issue/store sequencing FSM plus sticky protocol-error detection.
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        vl_d           = vl_q;
        sew_d          = sew_q;
        is_store_d     = is_store_q;
        sb_id_d        = sb_id_q;
        beats_d        = beats_q;
        beat_cnt_d     = beat_cnt_q;
        store_credit_d = 1'b0;
        err_d          = err_q;

        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    instr_d    = INSTR;
                    vl_d       = INSTR_VL;
                    sew_d      = INSTR_SEW;
                    is_store_d = INSTR_IS_STORE;
                    sb_id_d    = alloc_tag;
                    beats_d    = beats_calc;
                    beat_cnt_d = 13'd0;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = (is_store_q && (beats_q != 13'd0)) ? S_STORE_RX : S_IDLE;
            end
            S_STORE_RX: begin
                if (STORE_VALID) begin
                    store_credit_d = 1'b1;
                    beat_cnt_d     = beat_cnt_q + 13'd1;
                    if ((beat_cnt_q + 13'd1) == beats_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (STORE_VALID && (state_q != S_STORE_RX)) begin
            err_d = 1'b1;
        end
        if (COMPLETED_VALID && !busy_q[COMPLETED_SB_ID]) begin
            err_d = 1'b1;
        end
        if (ISSUE_CREDIT && (state_q != S_ISSUE) && (credits_q == 4'(INIT_CREDITS))) begin
            err_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            credits_q      <= 4'(INIT_CREDITS);
            busy_q         <= '0;
            in_flight_q    <= '0;
            instr_q        <= '0;
            vl_q           <= '0;
            sew_q          <= '0;
            is_store_q     <= 1'b0;
            sb_id_q        <= '0;
            beats_q        <= '0;
            beat_cnt_q     <= '0;
            store_credit_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            credits_q      <= credits_d;
            busy_q         <= busy_d;
            in_flight_q    <= in_flight_d;
            instr_q        <= instr_d;
            vl_q           <= vl_d;
            sew_q          <= sew_d;
            is_store_q     <= is_store_d;
            sb_id_q        <= sb_id_d;
            beats_q        <= beats_d;
            beat_cnt_q     <= beat_cnt_d;
            store_credit_q <= store_credit_d;
            err_q          <= err_d;
        end
    end

    assign ISSUE_VALID  = (state_q == S_ISSUE);
    assign ISSUE_INSTR  = instr_q;
    assign ISSUE_VL     = vl_q;
    assign ISSUE_SEW    = sew_q;
    assign ISSUE_SB_ID  = sb_id_q;
    assign STORE_CREDIT = store_credit_q;
    assign IN_FLIGHT    = in_flight_q;
    assign DRAINED      = (state_q == S_IDLE) && (in_flight_q == '0);
    assign ERR          = err_q;

endmodule

// File: tb/tb_ovi_issue_sched.sv
// Scoreboard bench for ovi_issue_sched: the driver pushes expected issues and
// store credits (with the cycle they must appear) into queues, a forked monitor
// pops and compares them, and a transaction-level model tracks credits/tags/errors.
module tb_ovi_issue_sched;
    localparam int INIT = 4;
    localparam int NT   = 32;
    localparam int TW   = 5;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          HALT = 1'b0;
    logic          INSTR_VALID = 1'b0;
    logic          INSTR_READY;
    logic [31:0]   INSTR = '0;
    logic [14:0]   INSTR_VL = '0;
    logic [1:0]    INSTR_SEW = '0;
    logic          INSTR_IS_STORE = 1'b0;
    logic          ISSUE_VALID;
    logic [31:0]   ISSUE_INSTR;
    logic [14:0]   ISSUE_VL;
    logic [1:0]    ISSUE_SEW;
    logic [TW-1:0] ISSUE_SB_ID;
    logic          ISSUE_CREDIT = 1'b0;
    logic          COMPLETED_VALID = 1'b0;
    logic [TW-1:0] COMPLETED_SB_ID = '0;
    logic          STORE_VALID = 1'b0;
    logic          STORE_CREDIT;
    logic [TW:0]   IN_FLIGHT;
    logic          DRAINED;
    logic          ERR;

    ovi_issue_sched #(.INIT_CREDITS(INIT), .NUM_TAGS(NT), .TAG_W(TW)) dut (
        .CLK(CLK), .RST(RST), .HALT(HALT),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTR(INSTR),
        .INSTR_VL(INSTR_VL), .INSTR_SEW(INSTR_SEW), .INSTR_IS_STORE(INSTR_IS_STORE),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_INSTR(ISSUE_INSTR), .ISSUE_VL(ISSUE_VL),
        .ISSUE_SEW(ISSUE_SEW), .ISSUE_SB_ID(ISSUE_SB_ID), .ISSUE_CREDIT(ISSUE_CREDIT),
        .COMPLETED_VALID(COMPLETED_VALID), .COMPLETED_SB_ID(COMPLETED_SB_ID),
        .STORE_VALID(STORE_VALID), .STORE_CREDIT(STORE_CREDIT),
        .IN_FLIGHT(IN_FLIGHT), .DRAINED(DRAINED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] instr;
        logic [14:0] vl;
        logic [1:0]  sew;
        int          tag;
        int          cyc;
    } iss_t;

    iss_t iss_q[$];
    int   sc_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    // Reference model state
    int   m_credits;
    bit   m_busy[NT];
    int   m_in_flight;
    bit   m_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic bit model_ready();
        return !HALT && (m_credits > 0) && (lowest_free() >= 0);
    endfunction

    function automatic int pick_busy();
        int cand[$];
        for (int i = 0; i < NT; i++) if (m_busy[i]) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    task automatic m_credit_ret();
        if (m_credits == INIT) m_err = 1'b1;
        else m_credits++;
    endtask

    task automatic m_complete(input int t);
        if (m_busy[t]) begin
            m_busy[t] = 1'b0;
            m_in_flight--;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; HALT = 1'b0; INSTR_VALID = 1'b0; ISSUE_CREDIT = 1'b0;
        COMPLETED_VALID = 1'b0; STORE_VALID = 1'b0;
        tick();
        tick();
        iss_q.delete();
        sc_q.delete();
        m_credits = INIT; m_in_flight = 0; m_err = 1'b0;
        for (int i = 0; i < NT; i++) m_busy[i] = 1'b0;
        @(negedge CLK);
        chk("rst_issue_valid", ISSUE_VALID, 0);
        chk("rst_instr_ready", INSTR_READY, 0);
        chk("rst_issue_instr", ISSUE_INSTR, 0);
        chk("rst_issue_vl", ISSUE_VL, 0);
        chk("rst_issue_sew", ISSUE_SEW, 0);
        chk("rst_issue_sb_id", ISSUE_SB_ID, 0);
        chk("rst_store_credit", STORE_CREDIT, 0);
        chk("rst_in_flight", IN_FLIGHT, 0);
        chk("rst_err", ERR, 0);
        chk("rst_drained", DRAINED, 1);
        RST = 1'b0;
        tick();
    endtask

    task automatic check_status();
        @(negedge CLK);
        chk("in_flight", IN_FLIGHT, m_in_flight);
        chk("drained", DRAINED, (m_in_flight == 0));
        chk("err", ERR, m_err);
        tick();
    endtask

    // cmp_tag: -1 none, -2 random busy tag, else that tag; completed during the issue cycle.
    // beats_lim: -1 send every store beat, else stop after that many (stays in store reception).
    task automatic do_issue(input logic [31:0] w, input logic [14:0] vl, input logic [1:0] sew,
                            input bit st, input bit cr_at_issue, input int cmp_tag, input int beats_lim);
        bit   acc;
        int   tag;
        int   beats;
        int   ct;
        iss_t e;
        INSTR = w; INSTR_VL = vl; INSTR_SEW = sew; INSTR_IS_STORE = st; INSTR_VALID = 1'b1;
        @(negedge CLK);
        acc = model_ready();
        chk("instr_ready", INSTR_READY, acc);
        if (acc) begin
            tag = lowest_free();
            e.instr = w; e.vl = vl; e.sew = sew; e.tag = tag; e.cyc = cyc + 1;
            iss_q.push_back(e);
            m_busy[tag] = 1'b1;
            m_in_flight++;
            m_credits--;
        end
        tick();
        INSTR_VALID = 1'b0;
        if (!acc) return;
        if (cr_at_issue) begin
            ISSUE_CREDIT = 1'b1;
            m_credit_ret();
        end
        ct = (cmp_tag == -2) ? pick_busy() : cmp_tag;
        if (ct >= 0) begin
            COMPLETED_VALID = 1'b1;
            COMPLETED_SB_ID = TW'(ct);
            m_complete(ct);
        end
        @(negedge CLK);
        chk("ready_in_issue", INSTR_READY, 0);
        tick();
        ISSUE_CREDIT = 1'b0;
        COMPLETED_VALID = 1'b0;
        beats = (int'(vl) * (8 << sew) + 511) / 512;
        if (st) begin
            for (int b = 0; b < beats; b++) begin
                if (beats_lim >= 0 && b >= beats_lim) return;
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge CLK);
                    chk("ready_store_gap", INSTR_READY, 0);
                    tick();
                end
                STORE_VALID = 1'b1;
                @(negedge CLK);
                sc_q.push_back(cyc + 1);
                chk("ready_in_store", INSTR_READY, 0);
                tick();
                STORE_VALID = 1'b0;
            end
        end
    endtask

    task automatic give_credit();
        ISSUE_CREDIT = 1'b1;
        m_credit_ret();
        tick();
        ISSUE_CREDIT = 1'b0;
    endtask

    task automatic complete(input int t);
        COMPLETED_VALID = 1'b1;
        COMPLETED_SB_ID = TW'(t);
        m_complete(t);
        tick();
        COMPLETED_VALID = 1'b0;
    endtask

    initial begin
        int op;
        int t;
        fork
            forever begin
                @(posedge CLK);
                cyc++;
            end
            forever begin
                @(negedge CLK);
                if (!RST) begin
                    if (ISSUE_VALID) begin
                        chk("issue_expected", (iss_q.size() > 0), 1);
                        if (iss_q.size() > 0) begin
                            iss_t e;
                            e = iss_q.pop_front();
                            chk("issue_instr", ISSUE_INSTR, e.instr);
                            chk("issue_vl", ISSUE_VL, e.vl);
                            chk("issue_sew", ISSUE_SEW, e.sew);
                            chk("issue_sb_id", ISSUE_SB_ID, e.tag);
                            chk("issue_cycle", cyc, e.cyc);
                            $display("issue: cyc=%0d sb_id=%0d instr=%08h vl=%0d sew=%0d",
                                     cyc, ISSUE_SB_ID, ISSUE_INSTR, ISSUE_VL, ISSUE_SEW);
                        end
                    end
                    if (STORE_CREDIT) begin
                        chk("store_credit_expected", (sc_q.size() > 0), 1);
                        if (sc_q.size() > 0) begin
                            chk("store_credit_cycle", cyc, sc_q.pop_front());
                            $display("store credit: cyc=%0d", cyc);
                        end
                    end
                end
            end
        join_none

        // 1. credit-limited issue: four tags 0..3, then a returned credit lets tag 4 go
        do_reset();
        for (int i = 0; i < 6; i++) do_issue($urandom, 15'(i + 1), 2'd1, 1'b0, 1'b0, -1, -1);
        check_status();
        give_credit();
        do_issue(32'hA5A5_0005, 15'd7, 2'd0, 1'b0, 1'b0, -1, -1);
        check_status();

        // 2. store beat sequencing: 1 beat then 4 beats
        do_reset();
        do_issue(32'h0000_1027, 15'd8, 2'd2, 1'b1, 1'b0, -1, -1);
        check_status();
        give_credit();
        do_issue(32'h0000_2027, 15'd32, 2'd3, 1'b1, 1'b0, -1, -1);
        check_status();
        do_issue(32'h0000_3027, 15'd0, 2'd3, 1'b1, 1'b0, -1, -1);
        check_status();

        // 3. fill all tags, free tag 17, reissue only the cycle after
        do_reset();
        for (int i = 0; i < NT; i++) do_issue($urandom, 15'd4, 2'd0, 1'b0, 1'b1, -1, -1);
        check_status();
        do_issue(32'hDEAD_0001, 15'd1, 2'd0, 1'b0, 1'b0, -1, -1);
        INSTR = 32'hDEAD_0017; INSTR_VL = 15'd3; INSTR_SEW = 2'd1; INSTR_IS_STORE = 1'b0;
        INSTR_VALID = 1'b1;
        COMPLETED_VALID = 1'b1;
        COMPLETED_SB_ID = TW'(17);
        @(negedge CLK);
        chk("ready_on_free_cycle", INSTR_READY, model_ready());
        m_complete(17);
        tick();
        COMPLETED_VALID = 1'b0;
        do_issue(32'hDEAD_0017, 15'd3, 2'd1, 1'b0, 1'b0, -1, -1);
        check_status();

        // 4. issue + credit return + completion in the same cycle
        complete(3);
        complete(5);
        check_status();
        do_issue(32'hCAFE_0004, 15'd9, 2'd2, 1'b0, 1'b1, 9, -1);
        check_status();
        do_issue(32'hCAFE_0005, 15'd9, 2'd2, 1'b0, 1'b1, 11, -1);
        check_status();

        // 5. protocol errors, each sticky
        do_reset();
        complete(7);
        check_status();
        tick();
        check_status();
        do_reset();
        STORE_VALID = 1'b1;
        m_err = 1'b1;
        tick();
        STORE_VALID = 1'b0;
        check_status();
        check_status();
        do_reset();
        give_credit();
        check_status();
        for (int i = 0; i < 5; i++) do_issue($urandom, 15'd2, 2'd0, 1'b0, 1'b0, -1, -1);
        check_status();

        // 6. HALT blocks handshake; reset in the middle of store reception
        do_reset();
        HALT = 1'b1;
        do_issue(32'hBEEF_0001, 15'd5, 2'd0, 1'b0, 1'b0, -1, -1);
        HALT = 1'b0;
        check_status();
        do_issue(32'hBEEF_0002, 15'd100, 2'd3, 1'b1, 1'b0, -1, 2);
        do_reset();
        check_status();

        // Randomised traffic
        do_reset();
        for (int n = 0; n < 250; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                HALT = ($urandom_range(0, 9) == 0);
                do_issue($urandom, 15'($urandom_range(0, 150)), 2'($urandom_range(0, 3)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 2) == 0) ? -2 : -1, -1);
                HALT = 1'b0;
            end else if (op <= 6) begin
                if (m_credits < INIT) give_credit();
                else tick();
            end else if (op <= 8) begin
                t = pick_busy();
                if (t >= 0) complete(t);
                else tick();
            end else begin
                tick();
            end
            check_status();
        end

        repeat (3) tick();
        chk("issue_queue_drained", iss_q.size(), 0);
        chk("store_queue_drained", sc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
